cc_frame_decoder: RTL and testbench
===================================

CC_FRAME_DECODER -- requirements
Module: cc_frame_decoder

Interface
REQ-001 SHALL have parameter NUM_RX, default 4 (1..8): number of receiver frequency registers.
REQ-002 SHALL have parameter FREQ_W, default 32: frequency word width, in Hz.
REQ-003 SHALL have parameter ADDR_W, default 4: card address width.
REQ-004 SHALL have parameter PARITY_EN, default 1: when 1, the frame carries a trailing even-parity bit.
REQ-005 SHALL have port CBCLK, input, 1 bit: the single clock, all logic on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port CLRCLK, input, 1 bit: frame marker, synchronous to CBCLK.
REQ-008 SHALL have port CC, input, 1 bit: serial C&C data, MSB first.
REQ-009 SHALL have port ADDRESS, input, ADDR_W bits: address to match.
REQ-010 SHALL have port PTT_out, output, 1 bit: PTT from the host.
REQ-011 SHALL have port frequency_HZ, output, NUM_RX*FREQ_W bits: flattened frequency array; receiver k occupies bits [k*FREQ_W +: FREQ_W].
REQ-012 SHALL have port ctrl, output, 18 bits: control word {clock_select[3:0], OC[6:0], MODE, PGA, DITHER, RAND, ATTEN[1:0], spare}.
REQ-013 SHALL have port ref_ext, output, 1 bit: equal to clock_select[1].
REQ-014 SHALL have port source_122MHZ, output, 1 bit: equal to clock_select[2].
REQ-015 SHALL have port frame_valid, output, 1 bit: one-cycle pulse when an addressed frame is committed.
REQ-016 SHALL have port parity_err, output, 1 bit: one-cycle pulse on a parity failure.
REQ-017 SHALL have port frame_err, output, 1 bit: one-cycle pulse on a truncated frame.
REQ-018 SHALL have port err_count, output, 8 bits: saturating count of parity and framing errors.

Function
REQ-019 SHALL use frame layout, MSB first: {PTT, ADDR[ADDR_W-1:0], RX_SEL[2:0], FREQ[FREQ_W-1:0], CTRL[17:0], PAR if PARITY_EN}, with FRAME_BITS = 1+ADDR_W+3+FREQ_W+18+PARITY_EN (59 at defaults).
REQ-020 SHALL use states IDLE, ARM, SHIFT and CHECK; reset state is IDLE.
REQ-021 SHALL, in IDLE, move to ARM on the first edge that samples CLRCLK=1.
REQ-022 SHALL, in ARM, stay while CLRCLK=1; on the edge sampling CLRCLK=0, load the bit counter with FRAME_BITS-1 and go to SHIFT (this is the detection edge).
REQ-023 SHALL, in SHIFT, capture CC into the shift register on each edge starting with the edge after detection, counting down, and go to CHECK after the capture at count 0.
REQ-024 SHALL ignore CLRCLK high alone during SHIFT.
REQ-025 SHALL treat a CLRCLK 1->0 transition (sampled history 1 then current 0) during SHIFT with count > 0 as a framing error: pulse frame_err, increment err_count, discard partial data, and reload the counter as a new detection edge (stay in SHIFT).
REQ-026 SHALL, in CHECK (one cycle, then IDLE), fail parity when PARITY_EN=1 and the XOR of all FRAME_BITS bits is 1; on failure pulse parity_err, increment err_count and update no output.
REQ-027 SHALL, when parity passes, always update PTT_out.
REQ-028 SHALL, when parity passes and ADDR==ADDRESS, update ctrl and pulse frame_valid.
REQ-029 SHALL, when RX_SEL<NUM_RX, additionally update receiver RX_SEL's frequency; RX_SEL>=NUM_RX leaves all frequencies unchanged.
REQ-030 SHALL make updated outputs visible after the CHECK edge: latency 2 edges from the last data bit.
REQ-031 SHALL hold err_count at 255 with no wrap.
REQ-032 SHALL produce each pulse output high for exactly one cycle.

Reset
REQ-033 SHALL, while reset is asserted, force state IDLE, counter 0, shift register 0, PTT_out 0, all frequencies 0, ctrl 0 (so ref_ext=0 and source_122MHZ=0), all pulses 0 and err_count 0.
REQ-034 SHALL discard a frame in progress on reset, with no pulse and no update.
REQ-035 SHALL require, after reset release, a full CLRCLK high->low sequence before capturing.

Structure
REQ-036 SHALL place the state encoding, the CTRL field bit positions and the FRAME_BITS derivation function in package cc_pkg.
REQ-037 SHALL use one sub-module, cc_shift_rx, containing the state machine, counter and shift register, and exposing the frame word plus a done pulse; commit logic stays in the top level.

Verification
REQ-038 SHALL cover: defaults, ADDRESS=4'h3, frame PTT=1, ADDR=3, RX_SEL=2, FREQ=32'd7_100_000, CTRL=18'h0_0006 (clock_select=0), good parity -> 2 edges after the last bit, rx2=7100000, rx0/1/3 unchanged, PTT_out=1, frame_valid single pulse.
REQ-039 SHALL cover: same frame with parity bit inverted -> parity_err pulse, err_count=1, no output change.
REQ-040 SHALL cover: ADDR=5 with PTT=1 -> PTT_out=1, frequencies and ctrl unchanged, no frame_valid.
REQ-041 SHALL cover: CLRCLK 1->0 after 20 bits captured -> frame_err pulse, then a following complete frame decodes correctly.
REQ-042 SHALL cover: RX_SEL=7 with NUM_RX=4 -> ctrl updated, no frequency updated; 300 bad-parity frames -> err_count=255.

Source files
------------

// File: rtl/cc_pkg.sv
// Shared definitions for the C&C frame decoder: FSM encoding, control-word
// field positions and frame-length derivation.
package cc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARM   = 2'd1,
        ST_SHIFT = 2'd2,
        ST_CHECK = 2'd3
    } cc_state_e;

    localparam int unsigned RX_SEL_W = 3;
    localparam int unsigned CTRL_W   = 18;

    // ctrl = {clock_select[3:0], OC[6:0], MODE, PGA, DITHER, RAND, ATTEN[1:0], spare}
    localparam int unsigned CTRL_SPARE_BIT  = 0;
    localparam int unsigned CTRL_ATTEN_LSB  = 1;
    localparam int unsigned CTRL_RAND_BIT   = 3;
    localparam int unsigned CTRL_DITHER_BIT = 4;
    localparam int unsigned CTRL_PGA_BIT    = 5;
    localparam int unsigned CTRL_MODE_BIT   = 6;
    localparam int unsigned CTRL_OC_LSB     = 7;
    localparam int unsigned CTRL_CLKSEL_LSB = 14;
    localparam int unsigned CTRL_REF_EXT_BIT = CTRL_CLKSEL_LSB + 1;
    localparam int unsigned CTRL_SRC122_BIT  = CTRL_CLKSEL_LSB + 2;

    // Total serial frame length: PTT + ADDR + RX_SEL + FREQ + CTRL (+ parity)
    function automatic int unsigned frame_bits(input int unsigned addr_w,
                                               input int unsigned freq_w,
                                               input int unsigned parity_en);
        return 1 + addr_w + RX_SEL_W + freq_w + CTRL_W + parity_en;
    endfunction

endpackage

// File: rtl/cc_shift_rx.sv
// Frame receiver: detects the CLRCLK high->low marker, shifts FRAME_BITS of
// CC data MSB first and pulses done_o for the single CHECK cycle.
// Ports: clk_i/rst_i clock and async reset, clrclk_i frame marker, cc_i data,
//        frame_o captured frame word, done_o frame-complete pulse,
//        trunc_c (combinational) marker seen mid-frame on this edge.
module cc_shift_rx
    import cc_pkg::*;
#(
    parameter int unsigned FRAME_BITS = 59
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clrclk_i,
    input  logic                  cc_i,
    output logic [FRAME_BITS-1:0] frame_o,
    output logic                  done_o,
    output logic                  trunc_c
);

    localparam int unsigned        CNT_W    = $clog2(FRAME_BITS);
    localparam logic [CNT_W-1:0]   CNT_LOAD = CNT_W'(FRAME_BITS - 1);

    cc_state_e               state_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [FRAME_BITS-1:0]   sr_q;
    logic                    clr_q;
    logic                    done_q;

    // A fresh 1->0 marker before the last bit restarts the frame.
    assign trunc_c = (state_q == ST_SHIFT) && clr_q && !clrclk_i && (cnt_q != '0);

    assign frame_o = sr_q;
    assign done_o  = done_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            sr_q    <= '0;
            clr_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            clr_q  <= clrclk_i;
            done_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (clrclk_i) state_q <= ST_ARM;
                end
                ST_ARM: begin
                    if (!clrclk_i) begin
                        cnt_q   <= CNT_LOAD;
                        state_q <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (trunc_c) begin
                        cnt_q <= CNT_LOAD;
                        sr_q  <= '0;
                    end else begin
                        sr_q <= {sr_q[FRAME_BITS-2:0], cc_i};
                        if (cnt_q == '0) begin
                            state_q <= ST_CHECK;
                            done_q  <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q - CNT_W'(1);
                        end
                    end
                end
                ST_CHECK: begin
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/cc_frame_decoder.sv
// C&C serial frame decoder: receives frames via cc_shift_rx, checks parity and
// address, and commits PTT, per-receiver frequency and the control word.
// Ports: CBCLK clock, reset async active-high, CLRCLK frame marker, CC data,
//        ADDRESS card address; PTT_out, frequency_HZ (flattened per receiver),
//        ctrl, ref_ext/source_122MHZ (clock_select bits), frame_valid,
//        parity_err, frame_err one-cycle pulses, err_count saturating errors.
module cc_frame_decoder
    import cc_pkg::*;
#(
    parameter int unsigned NUM_RX    = 4,
    parameter int unsigned FREQ_W    = 32,
    parameter int unsigned ADDR_W    = 4,
    parameter int unsigned PARITY_EN = 1
) (
    input  logic                     CBCLK,
    input  logic                     reset,
    input  logic                     CLRCLK,
    input  logic                     CC,
    input  logic [ADDR_W-1:0]        ADDRESS,
    output logic                     PTT_out,
    output logic [NUM_RX*FREQ_W-1:0] frequency_HZ,
    output logic [CTRL_W-1:0]        ctrl,
    output logic                     ref_ext,
    output logic                     source_122MHZ,
    output logic                     frame_valid,
    output logic                     parity_err,
    output logic                     frame_err,
    output logic [7:0]               err_count
);

    localparam int unsigned FRAME_BITS = frame_bits(ADDR_W, FREQ_W, PARITY_EN);
    localparam int unsigned CTRL_LSB   = PARITY_EN;
    localparam int unsigned FREQ_LSB   = CTRL_LSB + CTRL_W;
    localparam int unsigned RX_LSB     = FREQ_LSB + FREQ_W;
    localparam int unsigned ADDR_LSB   = RX_LSB + RX_SEL_W;
    localparam int unsigned PTT_BIT    = ADDR_LSB + ADDR_W;

    logic [FRAME_BITS-1:0] frame;
    logic                  done;
    logic                  trunc;

    cc_shift_rx #(
        .FRAME_BITS (FRAME_BITS)
    ) u_rx (
        .clk_i    (CBCLK),
        .rst_i    (reset),
        .clrclk_i (CLRCLK),
        .cc_i     (CC),
        .frame_o  (frame),
        .done_o   (done),
        .trunc_c  (trunc)
    );

    // Field extraction from the captured frame word
    logic                f_ptt;
    logic [ADDR_W-1:0]   f_addr;
    logic [RX_SEL_W-1:0] f_rx;
    logic [FREQ_W-1:0]   f_freq;
    logic [CTRL_W-1:0]   f_ctrl;
    logic                parity_ok;
    logic                err_inc;

    assign f_ptt  = frame[PTT_BIT];
    assign f_addr = frame[ADDR_LSB +: ADDR_W];
    assign f_rx   = frame[RX_LSB +: RX_SEL_W];
    assign f_freq = frame[FREQ_LSB +: FREQ_W];
    assign f_ctrl = frame[CTRL_LSB +: CTRL_W];

    // Even parity over the whole frame; always passes without a parity bit
    assign parity_ok = (PARITY_EN == 0) || !(^frame);
    assign err_inc   = trunc || (done && !parity_ok);

    logic                     ptt_q;
    logic [NUM_RX*FREQ_W-1:0] freq_q;
    logic [CTRL_W-1:0]        ctrl_q;
    logic                     fv_q;
    logic                     pe_q;
    logic                     fe_q;
    logic [7:0]               err_q;

    // Commit and error bookkeeping
    always_ff @(posedge CBCLK or posedge reset) begin
        if (reset) begin
            ptt_q  <= 1'b0;
            freq_q <= '0;
            ctrl_q <= '0;
            fv_q   <= 1'b0;
            pe_q   <= 1'b0;
            fe_q   <= 1'b0;
            err_q  <= '0;
        end else begin
            fv_q <= 1'b0;
            pe_q <= 1'b0;
            fe_q <= trunc;
            if (done) begin
                if (!parity_ok) begin
                    pe_q <= 1'b1;
                end else begin
                    ptt_q <= f_ptt;
                    if (f_addr == ADDRESS) begin
                        ctrl_q <= f_ctrl;
                        fv_q   <= 1'b1;
                        for (int unsigned k = 0; k < NUM_RX; k++) begin
                            if (32'(f_rx) == k) freq_q[k*FREQ_W +: FREQ_W] <= f_freq;
                        end
                    end
                end
            end
            if (err_inc && (err_q != 8'hFF)) err_q <= err_q + 8'd1;
        end
    end

    assign PTT_out       = ptt_q;
    assign frequency_HZ  = freq_q;
    assign ctrl          = ctrl_q;
    assign ref_ext       = ctrl_q[CTRL_REF_EXT_BIT];
    assign source_122MHZ = ctrl_q[CTRL_SRC122_BIT];
    assign frame_valid   = fv_q;
    assign parity_err    = pe_q;
    assign frame_err     = fe_q;
    assign err_count     = err_q;

endmodule

// File: tb/tb_cc_frame_decoder.sv
// Scoreboard bench for cc_frame_decoder at default parameters.
module tb_cc_frame_decoder;

    localparam int unsigned FB = 59;
    localparam logic [3:0]  DUT_ADDR = 4'h3;

    logic         CBCLK = 1'b0;
    logic         reset;
    logic         CLRCLK;
    logic         CC;
    logic [3:0]   ADDRESS;
    logic         PTT_out;
    logic [127:0] frequency_HZ;
    logic [17:0]  ctrl;
    logic         ref_ext;
    logic         source_122MHZ;
    logic         frame_valid;
    logic         parity_err;
    logic         frame_err;
    logic [7:0]   err_count;

    cc_frame_decoder dut (
        .CBCLK         (CBCLK),
        .reset         (reset),
        .CLRCLK        (CLRCLK),
        .CC            (CC),
        .ADDRESS       (ADDRESS),
        .PTT_out       (PTT_out),
        .frequency_HZ  (frequency_HZ),
        .ctrl          (ctrl),
        .ref_ext       (ref_ext),
        .source_122MHZ (source_122MHZ),
        .frame_valid   (frame_valid),
        .parity_err    (parity_err),
        .frame_err     (frame_err),
        .err_count     (err_count)
    );

    always #5 CBCLK = ~CBCLK;

    typedef struct {
        logic         fv;
        logic         pe;
        logic         fe;
        logic         ptt;
        logic [127:0] freq;
        logic [17:0]  ctrl;
        logic [7:0]   err;
    } exp_t;

    exp_t sb_q[$];

    // Reference model state
    logic         m_ptt;
    logic [127:0] m_freq;
    logic [17:0]  m_ctrl;
    logic [7:0]   m_err;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [FB-1:0] mk_frame(input logic ptt, input logic [3:0] addr,
                                               input logic [2:0] rx, input logic [31:0] freq,
                                               input logic [17:0] c, input logic bad);
        logic [FB-2:0] body;
        body = {ptt, addr, rx, freq, c};
        return {body, (^body) ^ bad};
    endfunction

    function automatic exp_t snap(input logic fv, input logic pe, input logic fe);
        exp_t e;
        e.fv = fv; e.pe = pe; e.fe = fe;
        e.ptt = m_ptt; e.freq = m_freq; e.ctrl = m_ctrl; e.err = m_err;
        return e;
    endfunction

    task automatic model_frame(input logic ptt, input logic [3:0] addr, input logic [2:0] rx,
                               input logic [31:0] freq, input logic [17:0] c, input logic bad);
        logic fv;
        fv = 1'b0;
        if (bad) begin
            if (m_err != 8'd255) m_err = m_err + 8'd1;
        end else begin
            m_ptt = ptt;
            if (addr == DUT_ADDR) begin
                m_ctrl = c;
                fv = 1'b1;
                if (rx < 3'd4) m_freq[32*int'(rx) +: 32] = freq;
            end
        end
        sb_q.push_back(snap(fv, bad, 1'b0));
    endtask

    task automatic check_result(input string tag);
        exp_t e;
        check({tag, "_sb"}, 128'(sb_q.size()), 128'(1));
        if (sb_q.size() == 0) return;
        e = sb_q.pop_front();
        check({tag, "_frame_valid"}, 128'(frame_valid),   128'(e.fv));
        check({tag, "_parity_err"},  128'(parity_err),    128'(e.pe));
        check({tag, "_frame_err"},   128'(frame_err),     128'(e.fe));
        check({tag, "_ptt"},         128'(PTT_out),       128'(e.ptt));
        check({tag, "_freq"},        frequency_HZ,        e.freq);
        check({tag, "_ctrl"},        128'(ctrl),          128'(e.ctrl));
        check({tag, "_ref_ext"},     128'(ref_ext),       128'(e.ctrl[15]));
        check({tag, "_src122"},      128'(source_122MHZ), 128'(e.ctrl[16]));
        check({tag, "_err_count"},   128'(err_count),     128'(e.err));
    endtask

    task automatic preamble();
        CLRCLK = 1'b1;
        @(negedge CBCLK);
        CLRCLK = 1'b0;
        @(negedge CBCLK);
    endtask

    // Shift all bits, then check: nothing before CHECK edge, result after it, pulse gone next.
    task automatic shift_frame(input logic [FB-1:0] fr, input string tag);
        for (int i = FB - 1; i >= 0; i--) begin
            CC = fr[i];
            @(negedge CBCLK);
        end
        check({tag, "_early"}, 128'({frame_valid, parity_err}), 128'(0));
        @(negedge CBCLK);
        check_result(tag);
        @(negedge CBCLK);
        check({tag, "_pulse_once"}, 128'({frame_valid, parity_err, frame_err}), 128'(0));
    endtask

    task automatic send_frame(input logic ptt, input logic [3:0] addr, input logic [2:0] rx,
                              input logic [31:0] freq, input logic [17:0] c, input logic bad,
                              input string tag);
        logic [FB-1:0] fr;
        fr = mk_frame(ptt, addr, rx, freq, c, bad);
        model_frame(ptt, addr, rx, freq, c, bad);
        preamble();
        shift_frame(fr, tag);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [FB-1:0] fr;
        logic          seen;

        reset = 1'b1; CLRCLK = 1'b0; CC = 1'b0; ADDRESS = DUT_ADDR;
        m_ptt = 1'b0; m_freq = '0; m_ctrl = '0; m_err = '0;
        repeat (3) @(negedge CBCLK);
        sb_q.push_back(snap(1'b0, 1'b0, 1'b0));
        check_result("reset");
        reset = 1'b0;
        @(negedge CBCLK);

        // Addressed good frame, receiver 2
        send_frame(1'b1, 4'h3, 3'd2, 32'd7_100_000, 18'h0_0006, 1'b0, "good_rx2");
        // Same frame, parity inverted
        send_frame(1'b1, 4'h3, 3'd2, 32'd7_100_000, 18'h0_0006, 1'b1, "bad_par");
        // PTT low, clock_select=3 -> ref_ext
        send_frame(1'b0, 4'h3, 3'd1, 32'd14_200_000, 18'h0_C000, 1'b0, "rx1_refext");
        // Other card's address: only PTT follows
        send_frame(1'b1, 4'h5, 3'd0, 32'd3_500_000, 18'h3_FFFF, 1'b0, "other_addr");

        // Marker mid-frame after 20 bits, then a complete frame
        fr = mk_frame(1'b1, 4'h3, 3'd0, 32'd1_234_567, 18'h2_AAAA, 1'b0);
        preamble();
        for (int i = FB - 1; i > FB - 21; i--) begin
            CC = fr[i];
            @(negedge CBCLK);
        end
        CC = 1'b0; CLRCLK = 1'b1;
        @(negedge CBCLK);
        CLRCLK = 1'b0;
        @(negedge CBCLK);
        m_err = m_err + 8'd1;
        sb_q.push_back(snap(1'b0, 1'b0, 1'b1));
        check_result("trunc");
        fr = mk_frame(1'b0, 4'h3, 3'd3, 32'd28_000_000, 18'h1_0000, 1'b0);
        model_frame(1'b0, 4'h3, 3'd3, 32'd28_000_000, 18'h1_0000, 1'b0);
        shift_frame(fr, "after_trunc");

        // Out-of-range receiver: ctrl only
        send_frame(1'b1, 4'h3, 3'd7, 32'd999, 18'h0_ABCD, 1'b0, "rx7");

        // Saturate the error counter
        for (int n = 0; n < 300; n++)
            send_frame(1'b1, 4'h3, 3'd0, 32'(n), 18'h0_0001, 1'b1, "sat");
        check("err_sat", 128'(err_count), 128'(255));

        // Reset in the middle of a frame discards it
        fr = mk_frame(1'b1, 4'h3, 3'd0, 32'd123, 18'h3_FFFF, 1'b0);
        preamble();
        for (int i = FB - 1; i > FB - 11; i--) begin
            CC = fr[i];
            @(negedge CBCLK);
        end
        reset = 1'b1;
        @(negedge CBCLK);
        m_ptt = 1'b0; m_freq = '0; m_ctrl = '0; m_err = '0;
        sb_q.push_back(snap(1'b0, 1'b0, 1'b0));
        check_result("mid_reset");
        reset = 1'b0;
        seen = 1'b0;
        for (int i = FB - 11; i >= 0; i--) begin
            CC = fr[i];
            @(negedge CBCLK);
            seen = seen | frame_valid | parity_err | frame_err;
        end
        repeat (3) @(negedge CBCLK);
        check("post_reset_pulse", 128'(seen), 128'(0));
        sb_q.push_back(snap(1'b0, 1'b0, 1'b0));
        check_result("post_reset_hold");
        send_frame(1'b1, 4'h3, 3'd0, 32'd10_000_000, 18'h0_0040, 1'b0, "post_reset_good");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
